// File: rtl/id_ex_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: reset PC, bubble word, exception codes.
// The optional stall counter is enabled by defining ID_EX_STALL_CNT_EN.
package id_ex_reg_pkg;
    localparam int XLEN = 32;
    localparam int EXC_W = 5;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [EXC_W-1:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;
endpackage

// File: rtl/id_ex_if.sv
// ID->EX stage bundle: decoded operands from ID, their registered copies toward EX.
// StallCnt exists only when ID_EX_STALL_CNT_EN is defined.
interface id_ex_if;
    import id_ex_reg_pkg::*;

    // Stall holds ID and injects a bubble; Flush clears the EX slot. Both are
    // level signals sampled on the same edge as the data, no handshake.
    logic             Stall;
    logic             Flush;
    logic [XLEN-1:0]  PC_D;
    logic [XLEN-1:0]  Instr_D;
    logic [XLEN-1:0]  RD1_D;
    logic [XLEN-1:0]  RD2_D;
    logic [XLEN-1:0]  EXT32_D;
    logic             BD_D;
    logic [EXC_W-1:0] ExcCode_D;

    logic [XLEN-1:0]  PC_E;
    logic [XLEN-1:0]  Instr_E;
    logic [XLEN-1:0]  RD1_E;
    logic [XLEN-1:0]  RD2_E;
    logic [XLEN-1:0]  EXT32_E;
    logic             BD_E;
    logic [EXC_W-1:0] ExcCode_E;
`ifdef ID_EX_STALL_CNT_EN
    logic [XLEN-1:0]  StallCnt;
`endif

    modport master (
        output Stall, Flush, PC_D, Instr_D, RD1_D, RD2_D, EXT32_D, BD_D, ExcCode_D,
        input  PC_E, Instr_E, RD1_E, RD2_E, EXT32_E, BD_E, ExcCode_E
`ifdef ID_EX_STALL_CNT_EN
        , input StallCnt
`endif
    );

    modport slave (
        input  Stall, Flush, PC_D, Instr_D, RD1_D, RD2_D, EXT32_D, BD_D, ExcCode_D,
        output PC_E, Instr_E, RD1_E, RD2_E, EXT32_E, BD_E, ExcCode_E
`ifdef ID_EX_STALL_CNT_EN
        , output StallCnt
`endif
    );
endinterface

// File: rtl/id_ex_reg_pipe_field.sv
// One pipeline field: priority reset > clear > bubble > load.
// PASS_ON_BUBBLE fields keep loading their input during a bubble (PC/BD for EPC).
module id_ex_reg_pipe_field #(
    parameter int             W              = 32,
    parameter logic [W-1:0]   RST_VAL        = '0,
    parameter logic [W-1:0]   BUB_VAL        = '0,
    parameter bit             PASS_ON_BUBBLE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = d;
        if (clr) begin
            q_d = RST_VAL;
        end else if (bubble) begin
            q_d = PASS_ON_BUBBLE ? d : BUB_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= RST_VAL;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with hazard-stall bubbles and CP0 flush.
// Define ID_EX_STALL_CNT_EN to add the StallCnt bubble counter.
module id_ex_reg
    import id_ex_reg_pkg::*;
(
    input logic  clk,
    input logic  reset,
    id_ex_if.slave io
);
    id_ex_reg_pipe_field #(.W(XLEN), .RST_VAL(RESET_PC), .BUB_VAL(RESET_PC), .PASS_ON_BUBBLE(1'b1))
        u_pc (.clk(clk), .rst(reset), .clr(io.Flush), .bubble(io.Stall), .d(io.PC_D), .q(io.PC_E));

    id_ex_reg_pipe_field #(.W(XLEN), .RST_VAL(NOP_INSTR), .BUB_VAL(NOP_INSTR), .PASS_ON_BUBBLE(1'b0))
        u_instr (.clk(clk), .rst(reset), .clr(io.Flush), .bubble(io.Stall), .d(io.Instr_D), .q(io.Instr_E));

    id_ex_reg_pipe_field #(.W(XLEN), .RST_VAL('0), .BUB_VAL('0), .PASS_ON_BUBBLE(1'b0))
        u_rd1 (.clk(clk), .rst(reset), .clr(io.Flush), .bubble(io.Stall), .d(io.RD1_D), .q(io.RD1_E));

    id_ex_reg_pipe_field #(.W(XLEN), .RST_VAL('0), .BUB_VAL('0), .PASS_ON_BUBBLE(1'b0))
        u_rd2 (.clk(clk), .rst(reset), .clr(io.Flush), .bubble(io.Stall), .d(io.RD2_D), .q(io.RD2_E));

    id_ex_reg_pipe_field #(.W(XLEN), .RST_VAL('0), .BUB_VAL('0), .PASS_ON_BUBBLE(1'b0))
        u_ext32 (.clk(clk), .rst(reset), .clr(io.Flush), .bubble(io.Stall), .d(io.EXT32_D), .q(io.EXT32_E));

    // BD travels with PC so a bubble still reports the held instruction's slot.
    id_ex_reg_pipe_field #(.W(1), .RST_VAL(1'b0), .BUB_VAL(1'b0), .PASS_ON_BUBBLE(1'b1))
        u_bd (.clk(clk), .rst(reset), .clr(io.Flush), .bubble(io.Stall), .d(io.BD_D), .q(io.BD_E));

    id_ex_reg_pipe_field #(.W(EXC_W), .RST_VAL(EXC_INT), .BUB_VAL(EXC_INT), .PASS_ON_BUBBLE(1'b0))
        u_exc (.clk(clk), .rst(reset), .clr(io.Flush), .bubble(io.Stall), .d(io.ExcCode_D), .q(io.ExcCode_E));

`ifdef ID_EX_STALL_CNT_EN
    logic [XLEN-1:0] stall_cnt_q;
    logic [XLEN-1:0] stall_cnt_d;

    // Counts only bubbles actually inserted; a flush wins over a stall and holds the count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (io.Stall && !io.Flush) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign io.StallCnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed test-plan steps then randomized traffic against a rule-level model.
// Counter checks are active when ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_reg;
    import id_ex_reg_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    id_ex_if bus ();

    id_ex_reg dut (.clk(clk), .reset(reset), .io(bus));

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: what EX should see after each edge
    logic [31:0] m_pc, m_instr, m_rd1, m_rd2, m_ext;
    logic        m_bd;
    logic [4:0]  m_exc;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic fl,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] ext, input logic bd, input logic [4:0] exc);
        reset         = r;
        bus.Stall     = st;
        bus.Flush     = fl;
        bus.PC_D      = pc;
        bus.Instr_D   = ins;
        bus.RD1_D     = rd1;
        bus.RD2_D     = rd2;
        bus.EXT32_D   = ext;
        bus.BD_D      = bd;
        bus.ExcCode_D = exc;
    endtask

    task automatic drive_rand(input logic r, input logic st, input logic fl);
        drive(r, st, fl, $urandom, $urandom, $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    endtask

    // One clock: model applies the action chosen by the priority rules, then compare.
    task automatic tick();
        @(posedge clk);
        if (reset || bus.Flush) begin
            m_pc = 32'h0000_3000; m_instr = 32'h0; m_rd1 = 32'h0; m_rd2 = 32'h0;
            m_ext = 32'h0; m_bd = 1'b0; m_exc = 5'd0;
            if (reset) m_cnt = 32'h0;
        end else if (bus.Stall) begin
            m_pc = bus.PC_D; m_bd = bus.BD_D;
            m_instr = 32'h0; m_rd1 = 32'h0; m_rd2 = 32'h0; m_ext = 32'h0; m_exc = 5'd0;
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_pc = bus.PC_D; m_instr = bus.Instr_D; m_rd1 = bus.RD1_D; m_rd2 = bus.RD2_D;
            m_ext = bus.EXT32_D; m_bd = bus.BD_D; m_exc = bus.ExcCode_D;
        end
        #1;
        check("pc_e",    bus.PC_E,            m_pc);
        check("instr_e", bus.Instr_E,         m_instr);
        check("rd1_e",   bus.RD1_E,           m_rd1);
        check("rd2_e",   bus.RD2_E,           m_rd2);
        check("ext32_e", bus.EXT32_E,         m_ext);
        check("bd_e",    32'(bus.BD_E),       32'(m_bd));
        check("exc_e",   32'(bus.ExcCode_E),  32'(m_exc));
`ifdef ID_EX_STALL_CNT_EN
        check("stall_cnt", bus.StallCnt, m_cnt);
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_cnt = 32'h0;

        // reset held two cycles with random inputs
        drive_rand(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        tick();
        drive_rand(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        tick();
        check("reset_pc", bus.PC_E, 32'h0000_3000);
        check("reset_instr", bus.Instr_E, 32'h0);

        // plain load
        drive(1'b0, 1'b0, 1'b0, 32'h3004, 32'h2408_FFFF, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        tick();
        check("load_ext", bus.EXT32_E, 32'hFFFF_FFFF);
        check("load_instr", bus.Instr_E, 32'h2408_FFFF);

        // two stall cycles of a delay-slot load
        drive(1'b0, 1'b1, 1'b0, 32'h3010, 32'h8D09_0004, 32'h11, 32'h22, 32'h4, 1'b1, 5'd0);
        tick();
        check("stall1_pc", bus.PC_E, 32'h3010);
        check("stall1_bd", 32'(bus.BD_E), 32'd1);
        tick();
        check("stall2_instr", bus.Instr_E, 32'h0);
`ifdef ID_EX_STALL_CNT_EN
        check("stall2_cnt", bus.StallCnt, 32'd2);
`endif
        bus.Stall = 1'b0;
        tick();
        check("release_instr", bus.Instr_E, 32'h8D09_0004);

        // flush and stall on the same edge
        drive(1'b0, 1'b1, 1'b1, 32'h3018, 32'h0000_000C, 32'h7, 32'h8, 32'h9, 1'b1, EXC_OV);
        tick();
        check("flush_pc", bus.PC_E, 32'h0000_3000);
        check("flush_exc", 32'(bus.ExcCode_E), 32'd0);
`ifdef ID_EX_STALL_CNT_EN
        check("flush_cnt_held", bus.StallCnt, 32'd2);
`endif

        // exception code passes through on a normal load
        drive(1'b0, 1'b0, 1'b0, 32'h3020, 32'hFC00_0000, 32'h0, 32'h0, 32'h0, 1'b0, EXC_RI);
        tick();
        check("exc_prop_code", 32'(bus.ExcCode_E), 32'd10);
        check("exc_prop_pc", bus.PC_E, 32'h3020);

`ifdef ID_EX_STALL_CNT_EN
        // counter wrap
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        drive_rand(1'b0, 1'b1, 1'b0);
        tick();
        check("cnt_wrap", bus.StallCnt, 32'h0);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'($urandom_range(0, 99) < 3),
                       1'($urandom_range(0, 99) < 30),
                       1'($urandom_range(0, 99) < 10));
            tick();
        end

        // reset mid-stream overrides stall/flush
        drive_rand(1'b1, 1'b1, 1'b0);
        tick();
        drive_rand(1'b0, 1'b0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the five-stage MIPS core with precise interrupts. It captures the decoded operands at the end of ID: PC, instruction, both GPR read values, the 32-bit extended immediate, the branch-delay flag and any pending exception code. It presents these to EX one cycle later. It also implements the hazard unit's stall (bubble insertion) and the CP0 flush, and keeps PC/BD intact through bubbles so EPC stays correct when an interrupt lands on a bubble.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset and flush.
- NOP_INSTR, 32'h0000_0000, instruction word for bubbles and cleared slots.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- Stall  in  1  hazard unit: ID is held this cycle, insert bubble into EX.
- Flush  in  1  CP0: exception/interrupt/eret taken; clear EX slot.
- PC_D  in  32  PC of instruction in ID.
- Instr_D  in  32  instruction word in ID.
- RD1_D, RD2_D  in  32 each  forwarded GPR read data.
- EXT32_D  in  32  extended immediate (sign, zero or lui form).
- BD_D  in  1  instruction in ID is in a branch delay slot.
- ExcCode_D  in  5  exception detected in IF/ID (0 = none).
- PC_E, Instr_E, RD1_E, RD2_E, EXT32_E  out  32 each  registered copies.
- BD_E  out  1; ExcCode_E  out  5  registered copies.
- StallCnt  out  32  bubbles inserted (present only with macro, see Configuration).

## Operation
- Each rising edge, exactly one action is taken. Priority is reset > Flush > Stall > load.
- Reset: PC_E=RESET_PC, Instr_E=NOP_INSTR, RD1_E=RD2_E=EXT32_E=0, BD_E=0, ExcCode_E=0, StallCnt=0.
- Flush: same values as reset, except StallCnt is held. Flush overrides a simultaneous Stall.
- Stall (Flush=0): bubble.
  - Instr_E=NOP_INSTR, RD1_E=RD2_E=EXT32_E=0, ExcCode_E=0.
  - PC_E<=PC_D and BD_E<=BD_D. The bubble carries the PC/BD of the held instruction, so CP0 computes EPC (PC or PC-4 when BD) correctly.
  - StallCnt increments.
- Load (neither asserted): every *_E output takes its *_D input unchanged. No arithmetic on the data path.
- Consecutive stalls produce consecutive identical bubbles. Release of Stall loads the held ID contents normally.
- The block does not decode the instruction. Bubble detection downstream is Instr_E==NOP_INSTR.

## Timing
- Latency: exactly 1 cycle from *_D to *_E. Outputs are pure flop outputs with no combinational path from inputs.
- Stall/Flush are sampled at the same edge as the data and take effect on the following cycle's outputs.
- Reset asserted mid-stream clears on the next edge regardless of Stall/Flush. The first load happens on the first edge after reset deasserts.
- StallCnt wraps 32'hFFFF_FFFF -> 0. It is not affected by Flush. Reset clears it.

## Configuration
- ID_EX_STALL_CNT_EN defined: StallCnt port and its 32-bit counter exist, behaving as above.
- Not defined: the StallCnt port and counter are absent. All other behaviour is bit-identical.

## Structure
- Shared include header holds the RESET_PC (0x3000) and NOP constants and the ExcCode encodings (Int=0, AdEL=4, AdES=5, RI=10, Ov=12). The parameter defaults reference these.
- One natural sub-module, pipe_field: a parameterised-width register with reset value, clear and bubble-value inputs. It is instantiated per field; PC and BD use the "pass on bubble" variant.

## Test plan
- Reset: hold reset 2 cycles with random inputs -> PC_E=0x3000, Instr_E=0, all others 0, StallCnt=0.
- Load: PC_D=0x3004, Instr_D=0x2408_FFFF, EXT32_D=0xFFFF_FFFF, RD1_D=5 -> identical values on *_E next cycle.
- Stall: PC_D=0x3010, BD_D=1, Instr_D=0x8D09_0004, Stall=1 for 2 cycles -> Instr_E=0, ExcCode_E=0, PC_E=0x3010, BD_E=1 both cycles; StallCnt=2. After release, Instr_E=0x8D09_0004.
- Flush+Stall same edge, ExcCode_D=12 -> PC_E=0x3000, Instr_E=0, ExcCode_E=0, BD_E=0; StallCnt unchanged.
- Exception propagation: ExcCode_D=10, PC_D=0x3020 with no stall -> ExcCode_E=10, PC_E=0x3020.
- Counter wrap (macro on): force StallCnt to 0xFFFF_FFFF, one stall -> 0. Macro off: build elaborates with no StallCnt port.
